// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read-port bundle between the byte FIFO and its UART transmitter.
interface fifo_uart_tx_if #(parameter int DATA_WIDTH = 8);
  logic                  fifoEmpty;
  logic [DATA_WIDTH-1:0] fifoData;
  logic                  fifoReadEn;
  modport master (input fifoEmpty, input fifoData, output fifoReadEn);
  modport slave (output fifoEmpty, output fifoData, input fifoReadEn);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the byte FIFO and sends each byte as an 8N1 frame on tx.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           txEnable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           byteDone
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic tx_q, tx_d, rd_q, rd_d;
  logic bit_end, go;
  always_comb begin
    bit_end = cnt_q == LAST_CLK;
    go = txEnable && !fifo.fifoEmpty;
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: state_d = go ? POP : IDLE;
      POP: state_d = LATCH;
      LATCH: begin
        state_d = START;
        shift_d = fifo.fifoData;
      end
      START: state_d = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        bit_d = bit_q == LAST_BIT ? '0 : bit_q + 1'b1;
        state_d = bit_q == LAST_BIT ? STOP : DATA;
      end
      STOP: state_d = bit_end ? (go ? POP : IDLE) : STOP;
      default: state_d = IDLE;
    endcase
    // Counter runs only in the timed states and restarts at every bit boundary and state entry
    cnt_d = (state_q inside {START, DATA, STOP}) && !bit_end ? cnt_q + 1'b1 : '0;
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[bit_d] : 1'b1;
    rd_d = state_d == POP;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      rd_q <= rd_d;
    end
  end
  assign tx = tx_q;
  assign fifo.fifoReadEn = rd_q;
  assign busy = state_q != IDLE;
  assign byteDone = state_q == STOP && bit_end;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboarded bench with a small FIFO model; a second instance covers the minimum bit period.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst, en, tx, busy, bd;
  logic en2, tx2, busy2, bd2, req2, taken2;
  logic wr_en, clr;
  logic [7:0] wr_data;
  logic [7:0] mem [16];
  logic [3:0] wp, rp;
  logic [7:0] exp_q [$];
  int total = 0, bad = 0, strobes = 0, strobes2 = 0, nframes = 0;
  logic rd_prev = 1'b0;
  fifo_uart_tx_if #(.DATA_WIDTH(8)) fif ();
  fifo_uart_tx_if #(.DATA_WIDTH(8)) fif2 ();
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(rst), .txEnable(en), .fifo(fif), .tx(tx), .busy(busy), .byteDone(bd));
  fifo_uart_tx #(.CLKS_PER_BIT(2), .DATA_WIDTH(8)) dut2 (
    .clk(clk), .reset(rst), .txEnable(en2), .fifo(fif2), .tx(tx2), .busy(busy2), .byteDone(bd2));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  assign fif.fifoEmpty = wp == rp;
  always @(posedge clk) begin
    if (wr_en) begin
      mem[wp] <= wr_data;
      wp <= wp + 4'd1;
    end
    if (clr) rp <= wp;
    else if (fif.fifoReadEn) begin
      fif.fifoData <= mem[rp];
      rp <= rp + 4'd1;
    end
  end
  assign fif2.fifoEmpty = !(req2 && !taken2);
  always @(posedge clk) begin
    if (fif2.fifoReadEn) begin
      fif2.fifoData <= 8'hFF;
      taken2 <= 1'b1;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask
  always @(negedge clk) begin
    if (fif.fifoReadEn) begin
      strobes++;
      chk("rd_single", 32'(rd_prev), 32'd0);
    end
    rd_prev = fif.fifoReadEn;
    if (fif2.fifoReadEn) strobes2++;
  end
  // Monitor: captures each frame bit by bit, then pops the expected byte at the stop bit
  initial begin
    logic [9:0] fr;
    logic stable, pulse_ok, abort;
    forever begin
      @(negedge clk);
      if (!rst && !tx) begin
        fr = '0;
        stable = 1'b1;
        pulse_ok = 1'b1;
        abort = 1'b0;
        for (int k = 0; k < 10 * CPB; k++) begin
          if (k > 0) @(negedge clk);
          if (rst) begin
            abort = 1'b1;
            break;
          end
          if (k % CPB == 0) fr[k / CPB] = tx;
          else if (tx !== fr[k / CPB]) stable = 1'b0;
          if (bd !== (k == 10 * CPB - 1)) pulse_ok = 1'b0;
        end
        if (!abort) begin
          nframes++;
          chk("frame_stable", 32'(stable), 32'd1);
          chk("byte_done_pos", 32'(pulse_ok), 32'd1);
          chk("start_stop", 32'({fr[9], fr[0]}), 32'd2);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got %0h want none", fr[8:1]);
          end else chk("frame_data", 32'(fr[8:1]), 32'(exp_q.pop_front()));
        end
      end
    end
  end
  task automatic wr(input logic [7:0] b, input bit expect_tx);
    if (expect_tx) exp_q.push_back(b);
    wr_data = b;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 400);
    chk(name, 32'(n < 400), 32'd1);
  endtask
  task automatic wait_start(input string name);
    int n = 0;
    while (tx && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 100), 32'd1);
  endtask
  initial begin
    int s0, f0, n, gap, lo, hi;
    logic all_hi, any_busy;
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; clr = 1'b0; wr_data = '0;
    wp = '0; rp = '0; fif.fifoData = '0;
    en2 = 1'b0; req2 = 1'b0; taken2 = 1'b0; fif2.fifoData = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd", 32'(fif.fifoReadEn), 32'd0);
    chk("rst_bd", 32'(bd), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    s0 = strobes; f0 = nframes;
    en = 1'b1;
    wr(8'hA5, 1'b1);
    wait_done("t1_done");
    chk("t1_strobes", 32'(strobes - s0), 32'd1);
    chk("t1_frames", 32'(nframes - f0), 32'd1);
    en = 1'b0;
    wr(8'h01, 1'b1);
    wr(8'h80, 1'b1);
    s0 = strobes;
    en = 1'b1;
    n = 0;
    while (!bd && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t2_first_done", 32'(bd), 32'd1);
    gap = 0;
    forever begin
      @(negedge clk);
      if (!tx || gap >= 10) break;
      gap++;
    end
    chk("t2_gap", 32'(gap), 32'd2);
    wait_done("t2_done");
    chk("t2_strobes", 32'(strobes - s0), 32'd2);
    chk("t2_empty", 32'(fif.fifoEmpty), 32'd1);
    chk("t2_idle", 32'(busy), 32'd0);
    s0 = strobes; all_hi = 1'b1; any_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!tx) all_hi = 1'b0;
      if (busy) any_busy = 1'b1;
    end
    chk("t3_tx_idle", 32'(all_hi), 32'd1);
    chk("t3_busy", 32'(any_busy), 32'd0);
    chk("t3_no_strobe", 32'(strobes - s0), 32'd0);
    wr(8'h3C, 1'b1);
    chk("t3_not_empty", 32'(fif.fifoEmpty), 32'd0);
    n = 0;
    while (tx && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t3_latency", 32'(n), 32'd3);
    wait_done("t3_done");
    en = 1'b0;
    wr(8'h55, 1'b1);
    wr(8'hAA, 1'b0);
    s0 = strobes;
    en = 1'b1;
    wait_start("t4_start");
    repeat (12) @(negedge clk);
    en = 1'b0;
    wait_done("t4_done");
    repeat (20) @(negedge clk);
    chk("t4_strobes", 32'(strobes - s0), 32'd1);
    chk("t4_left", 32'(fif.fifoEmpty), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    s0 = strobes;
    wr(8'hF0, 1'b0);
    en = 1'b1;
    wait_start("t5_start");
    repeat (18) @(negedge clk);
    chk("t5_bit3", 32'(tx), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_tx", 32'(tx), 32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_rd", 32'(fif.fifoReadEn), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    all_hi = 1'b1; any_busy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!tx) all_hi = 1'b0;
      if (busy) any_busy = 1'b1;
    end
    chk("t5_tx_idle", 32'(all_hi), 32'd1);
    chk("t5_busy", 32'(any_busy), 32'd0);
    chk("t5_strobes", 32'(strobes - s0), 32'd1);
    en = 1'b0;
    req2 = 1'b1;
    en2 = 1'b1;
    n = 0;
    while (tx2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    en2 = 1'b0;
    lo = 0;
    while (!tx2 && lo < 10) begin
      lo++;
      @(negedge clk);
    end
    chk("t6_start_len", 32'(lo), 32'd2);
    hi = 0;
    while (tx2 && hi < 30) begin
      hi++;
      if (bd2) break;
      @(negedge clk);
    end
    chk("t6_high_len", 32'(hi), 32'd18);
    @(negedge clk);
    chk("t6_bd_width", 32'(bd2), 32'd0);
    repeat (5) @(negedge clk);
    chk("t6_strobes", 32'(strobes2), 32'd1);
    chk("t6_busy", 32'(busy2), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
